// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - in-flight branch queue that checks predictions at mem and drives flush/redirect and predictor training
module branch_resolver #(
   parameter int DEPTH     = 4,
   parameter int CNT_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     decode_valid,
   input  logic [31:0]              decode_pc,
   input  logic [31:0]              decode_offset,
   input  logic                     decode_prediction,
   input  logic                     resolve_valid,
   input  logic                     resolve_taken,
   output logic                     mispredict,
   output logic [31:0]              redirect_pc,
   output logic                     update_valid,
   output logic                     update_taken,
   output logic [31:0]              update_pc,
   output logic [$clog2(DEPTH):0]   inflight,
   output logic                     overflow,
   output logic                     underflow,
   output logic [CNT_WIDTH-1:0]     branch_count,
   output logic [CNT_WIDTH-1:0]     mispredict_count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [31:0] pc_mem   [DEPTH];
   logic [31:0] tgt_mem  [DEPTH];
   logic        pred_mem [DEPTH];

   logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
   logic [PW:0]          count_q, count_d;
   logic                 mispredict_q, mispredict_d;
   logic                 update_valid_q, update_valid_d;
   logic                 update_taken_q, update_taken_d;
   logic [31:0]          redirect_pc_q, redirect_pc_d;
   logic [31:0]          update_pc_q, update_pc_d;
   logic                 overflow_q, overflow_d;
   logic                 underflow_q, underflow_d;
   logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
   logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

   logic        full, empty, pop, miss, push_ok;
   logic [31:0] h_pc, h_tgt;
   logic        h_pred;

   always_comb begin
      full    = (count_q == FULL_CNT);
      empty   = (count_q == '0);
      h_pc    = pc_mem[head_q];
      h_tgt   = tgt_mem[head_q];
      h_pred  = pred_mem[head_q];
      pop     = resolve_valid && !empty;
      miss    = pop && (h_pred != resolve_taken);
      // a push alongside a mispredicting pop is wrong-path and must not land
      push_ok = decode_valid && !miss && (!full || pop);

      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q;
      mispredict_d   = miss;
      update_valid_d = pop;
      update_taken_d = pop && resolve_taken;
      redirect_pc_d  = redirect_pc_q;
      update_pc_d    = update_pc_q;
      overflow_d     = overflow_q | (decode_valid && full && !pop);
      underflow_d    = underflow_q | (resolve_valid && empty);
      branch_cnt_d   = branch_cnt_q;
      miss_cnt_d     = miss_cnt_q;

      if (pop) begin
         head_d        = head_q + 1'b1;
         update_pc_d   = h_pc;
         redirect_pc_d = resolve_taken ? h_tgt : h_pc + 32'd4;
         if (branch_cnt_q != '1)
            branch_cnt_d = branch_cnt_q + 1'b1;
         if (miss && miss_cnt_q != '1)
            miss_cnt_d = miss_cnt_q + 1'b1;
      end

      if (miss) begin
         tail_d  = head_q + 1'b1;
         count_d = '0;
      end else begin
         if (push_ok)
            tail_d = tail_q + 1'b1;
         case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         pc_mem[tail_q]   <= decode_pc;
         tgt_mem[tail_q]  <= decode_pc + decode_offset;
         pred_mem[tail_q] <= decode_prediction;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         mispredict_q   <= 1'b0;
         update_valid_q <= 1'b0;
         update_taken_q <= 1'b0;
         redirect_pc_q  <= '0;
         update_pc_q    <= '0;
         overflow_q     <= 1'b0;
         underflow_q    <= 1'b0;
         branch_cnt_q   <= '0;
         miss_cnt_q     <= '0;
      end else begin
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         mispredict_q   <= mispredict_d;
         update_valid_q <= update_valid_d;
         update_taken_q <= update_taken_d;
         redirect_pc_q  <= redirect_pc_d;
         update_pc_q    <= update_pc_d;
         overflow_q     <= overflow_d;
         underflow_q    <= underflow_d;
         branch_cnt_q   <= branch_cnt_d;
         miss_cnt_q     <= miss_cnt_d;
      end
   end

   assign mispredict       = mispredict_q;
   assign redirect_pc      = redirect_pc_q;
   assign update_valid     = update_valid_q;
   assign update_taken     = update_taken_q;
   assign update_pc        = update_pc_q;
   assign inflight         = count_q;
   assign overflow         = overflow_q;
   assign underflow        = underflow_q;
   assign branch_count     = branch_cnt_q;
   assign mispredict_count = miss_cnt_q;

endmodule
